// File: rtl/max_vector_stream_ctrl_pkg.sv
// ============================================================================
// Module   : max_vector_stream_ctrl_pkg
// Brief    : Shared types and constants for the streaming vector-max controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package max_vector_stream_ctrl_pkg;

    localparam int DW    = 8;
    localparam int LANES = 8;
    localparam int CNT_W = 9;

    localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic             last;
        logic [CNT_W-1:0] idx;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/max_vector_stream_ctrl_tree.sv
// ============================================================================
// Module   : max_pipeline_tree
// Brief    : 8-lane signed max reduction, three register levels (8->4->2->1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_pipeline_tree
    import max_vector_stream_ctrl_pkg::*;
#(
    parameter int DW = max_vector_stream_ctrl_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [LANES*DW-1:0]  i_data,
    output logic                 o_valid,
    output logic signed [DW-1:0] o_max
);

    logic signed [DW-1:0] w_lane [LANES];
    logic signed [DW-1:0] r_l1   [LANES/2];
    logic signed [DW-1:0] r_l2   [LANES/4];
    logic signed [DW-1:0] r_l3;
    logic [2:0]           r_vld;

    function automatic logic signed [DW-1:0] f_smax(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign w_lane[g] = i_data[g*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LANES/2; i++) r_l1[i] <= '0;
            for (int i = 0; i < LANES/4; i++) r_l2[i] <= '0;
            r_l3 <= '0;
        end else begin
            r_vld <= {r_vld[1:0], i_valid};
            for (int i = 0; i < LANES/2; i++) r_l1[i] <= f_smax(w_lane[2*i], w_lane[2*i+1]);
            for (int i = 0; i < LANES/4; i++) r_l2[i] <= f_smax(r_l1[2*i], r_l1[2*i+1]);
            r_l3 <= f_smax(r_l2[0], r_l2[1]);
        end
    end

    assign o_valid = r_vld[2];
    assign o_max   = r_l3;

endmodule

`default_nettype wire

// File: rtl/max_vector_stream_ctrl.sv
// ============================================================================
// Module   : max_vector_stream_ctrl
// Brief    : Streams 8-lane beats through the max tree and folds a per-vector max.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_vector_stream_ctrl
    import max_vector_stream_ctrl_pkg::*;
#(
    parameter int DW        = max_vector_stream_ctrl_pkg::DW,
    parameter int TREE_LAT  = 3,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = max_vector_stream_ctrl_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [LANES*DW-1:0]  s_data,
    input  logic [LANES-1:0]     s_keep,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_max,
    output logic [CNT_W-1:0]     m_idx,
    output logic [CNT_W-1:0]     m_beats,
    output logic                 m_trunc
);

    localparam logic signed [DW-1:0] c_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam int                   c_IDX_W = max_vector_stream_ctrl_pkg::CNT_W;

    state_t                r_state, w_state_nxt;
    logic                  w_xfer, w_last_eff, w_tree_vld, w_fold, w_fold_last, w_gt;
    logic [LANES*DW-1:0]   w_tree_in;
    logic signed [DW-1:0]  w_tree_max, w_new_max, r_run_max;
    logic [CNT_W-1:0]      r_cnt, r_best_idx, w_new_idx, w_tail_idx;
    tag_t                  r_tag [TREE_LAT];
    logic [TREE_LAT-1:0]   r_tag_vld;
    logic                  r_trunc_pend;
    logic signed [DW-1:0]  r_m_max;
    logic [CNT_W-1:0]      r_m_idx, r_m_beats;
    logic                  r_m_trunc;

    assign w_xfer     = s_valid && (r_state == ACCEPT);
    assign w_last_eff = s_last || (r_cnt == CNT_W'(MAX_BEATS - 1));

    // Disabled lanes become the most negative value so they never win the max.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_mask
            assign w_tree_in[g*DW +: DW] = s_keep[g] ? s_data[g*DW +: DW] : c_MIN;
        end
    endgenerate

    max_pipeline_tree #(.DW(DW)) u_tree (
        .clk     (clk),
        .rst     (~rst),
        .i_valid (w_xfer),
        .i_data  (w_tree_in),
        .o_valid (w_tree_vld),
        .o_max   (w_tree_max)
    );

    assign w_tail_idx  = CNT_W'(r_tag[TREE_LAT-1].idx);
    assign w_fold      = w_tree_vld && r_tag_vld[TREE_LAT-1];
    assign w_fold_last = w_fold && r_tag[TREE_LAT-1].last;
    assign w_gt        = w_tree_max > r_run_max;
    assign w_new_max   = w_gt ? w_tree_max : r_run_max;
    assign w_new_idx   = w_gt ? w_tail_idx : r_best_idx;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ACCEPT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            ACCEPT: begin
                s_ready = 1'b1;
                if (s_valid && w_last_eff) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_fold_last) w_state_nxt = DONE;
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = ACCEPT;
            end
            default: w_state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_run_max    <= c_MIN;
            r_best_idx   <= '0;
            r_tag_vld    <= '0;
            r_trunc_pend <= 1'b0;
            r_m_max      <= '0;
            r_m_idx      <= '0;
            r_m_beats    <= '0;
            r_m_trunc    <= 1'b0;
            for (int i = 0; i < TREE_LAT; i++) r_tag[i] <= '0;
        end else begin
            // Tags advance every cycle in lockstep with the never-stalled tree.
            r_tag_vld[0] <= w_xfer;
            r_tag[0]     <= '{last: w_last_eff, idx: c_IDX_W'(r_cnt)};
            for (int i = 1; i < TREE_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag[i]     <= r_tag[i-1];
            end
            if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last_eff) r_trunc_pend <= !s_last;
            end
            if (w_fold) begin
                r_run_max  <= w_new_max;
                r_best_idx <= w_new_idx;
            end
            if (w_fold_last && (r_state == DRAIN)) begin
                r_m_max   <= w_new_max;
                r_m_idx   <= w_new_idx;
                r_m_beats <= r_cnt;
                r_m_trunc <= r_trunc_pend;
            end
            if ((r_state == DONE) && m_ready) begin
                r_cnt      <= '0;
                r_run_max  <= c_MIN;
                r_best_idx <= '0;
            end
        end
    end

    assign m_max   = r_m_max;
    assign m_idx   = r_m_idx;
    assign m_beats = r_m_beats;
    assign m_trunc = r_m_trunc;

endmodule

`default_nettype wire

// File: tb/tb_max_vector_stream_ctrl.sv
// ============================================================================
// Module   : tb_max_vector_stream_ctrl
// Brief    : Directed self-checking bench for max_vector_stream_ctrl (MAX_BEATS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_vector_stream_ctrl;
    import max_vector_stream_ctrl_pkg::*;

    localparam int TB_DW   = 8;
    localparam int TB_LAT  = 3;
    localparam int TB_MAXB = 4;
    localparam int TB_CW   = 9;

    logic                     clk     = 1'b0;
    logic                     rst     = 1'b0;
    logic                     s_valid = 1'b0;
    logic                     s_last  = 1'b0;
    logic                     m_ready = 1'b0;
    logic [LANES*TB_DW-1:0]   s_data  = '0;
    logic [LANES-1:0]         s_keep  = '0;
    logic                     s_ready, m_valid, m_trunc;
    logic signed [TB_DW-1:0]  m_max;
    logic [TB_CW-1:0]         m_idx, m_beats;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    int B0 [LANES] = '{-50, -20, -100, -5, -30, -90, -10, -60};
    int B1 [LANES] = '{-128, 0, 50, 120, -100, 50, 120, 127};
    int B2 [LANES] = '{30, 50, -80, 120, 0, 60, 70, 110};
    int T0 [LANES] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int T1 [LANES] = '{10, -3, 0, 9, 10, 2, -8, 5};
    int T2 [LANES] = '{0, 3, -7, 10, 99, 1, 2, 4};
    int T3 [LANES] = '{10, 10, 10, 10, 10, 10, 10, 10};
    int T4 [LANES] = '{5, 7, -1, 0, 3, 2, 1, 6};
    int T5 [LANES] = '{3, -2, 1, 0, -5, 2, 3, 1};

    always #5 clk = ~clk;

    max_vector_stream_ctrl #(
        .DW        (TB_DW),
        .TREE_LAT  (TB_LAT),
        .MAX_BEATS (TB_MAXB),
        .CNT_W     (TB_CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_max   (m_max),
        .m_idx   (m_idx),
        .m_beats (m_beats),
        .m_trunc (m_trunc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*TB_DW-1:0] pk(input int v [LANES]);
        logic [LANES*TB_DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*TB_DW +: TB_DW] = TB_DW'(v[i]);
        return r;
    endfunction

    // Returns just after the edge that transfers the beat.
    task automatic send(input int v [LANES], input logic [7:0] keep, input logic last);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = pk(v);
        s_keep  = keep;
        s_last  = last;
        while (!s_ready && n < 50) begin
            tick;
            n++;
        end
        chk("s_ready_on_accept", 32'(s_ready), 1);
        tick;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(output int l);
        l = 0;
        while (!m_valid && l < 40) begin
            tick;
            l++;
        end
        chk("result_valid", 32'(m_valid), 1);
    endtask

    task automatic check_result(input string tag, input int mx, input int idx,
                                input int beats, input int trunc);
        chk({tag, "_max"},   32'($signed(m_max)), mx);
        chk({tag, "_idx"},   32'(m_idx),   idx);
        chk({tag, "_beats"}, 32'(m_beats), beats);
        chk({tag, "_trunc"}, 32'(m_trunc), trunc);
    endtask

    task automatic handshake;
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk("post_hs_m_valid", 32'(m_valid), 0);
        chk("post_hs_s_ready", 32'(s_ready), 1);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick;
        tick;
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        check_result("rst", 0, 0, 0, 0);
        rst = 1'b1;
        tick;

        // Single beat; the accepting edge is the first of TREE_LAT+1 edges
        send(B0, 8'hFF, 1'b1);
        chk("drain_s_ready", 32'(s_ready), 0);
        wait_result(lat);
        chk("single_latency", lat, TB_LAT);
        check_result("single", -5, 0, 1, 0);
        handshake;

        // Three back-to-back beats
        send(B0, 8'hFF, 1'b0);
        send(B1, 8'hFF, 1'b0);
        send(B2, 8'hFF, 1'b1);
        wait_result(lat);
        check_result("three", 127, 1, 3, 0);
        handshake;

        // Masked lane 7 (127) and a tie at 120: the earlier beat wins
        send(B1, 8'h7F, 1'b0);
        send(B2, 8'hFF, 1'b1);
        wait_result(lat);
        check_result("mask", 120, 0, 2, 0);

        // Backpressure while a beat is offered during DONE
        s_valid = 1'b1;
        s_data  = pk(B2);
        s_keep  = 8'hFF;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_m_valid", 32'(m_valid), 1);
            chk("bp_m_max",   32'($signed(m_max)), 120);
            chk("bp_s_ready", 32'(s_ready), 0);
            tick;
        end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk("bp_hs_m_valid", 32'(m_valid), 0);
        chk("bp_hs_s_ready", 32'(s_ready), 1);
        tick;
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_result(lat);
        chk("bp_latency", lat, TB_LAT);
        check_result("bp", 120, 0, 1, 0);
        handshake;

        // Truncation at MAX_BEATS=4; the fifth beat starts the next vector
        send(T0, 8'hFF, 1'b0);
        send(T1, 8'hFF, 1'b0);
        send(T2, 8'hFF, 1'b0);
        send(T3, 8'hFF, 1'b0);
        s_valid = 1'b1;
        s_data  = pk(T4);
        s_keep  = 8'hFF;
        s_last  = 1'b0;
        wait_result(lat);
        check_result("trunc", 99, 2, 4, 1);
        chk("trunc_s_ready", 32'(s_ready), 0);
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk("trunc_hs_s_ready", 32'(s_ready), 1);
        tick;
        s_valid = 1'b0;
        send(T5, 8'hFF, 1'b1);
        wait_result(lat);
        check_result("after_trunc", 7, 0, 2, 0);
        handshake;

        // All lanes disabled still counts as a beat
        send(B1, 8'h00, 1'b1);
        wait_result(lat);
        check_result("nokeep", int'(MIN_VAL), 0, 1, 0);
        handshake;

        // Reset mid-vector discards in-flight beats
        send(T3, 8'hFF, 1'b0);
        send(B1, 8'hFF, 1'b0);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_s_ready", 32'(s_ready), 1);
        send(B2, 8'hFF, 1'b1);
        wait_result(lat);
        chk("midrst_latency", lat, TB_LAT);
        check_result("midrst", 120, 0, 1, 0);
        handshake;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_valid) seen++;
            tick;
        end
        chk("midrst_no_extra", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
